// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the arbiter/sequencer and a single APB slave.
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              PSEL1;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL1, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter in front of an APB master sequencer with wait-state timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | bus idle, arbitrating every cycle
// S_GRANT  | req_ready pulse out, payload latched, bus still idle
// S_SETUP  | PSEL1=1, PENABLE=0 on the bus
// S_ACCESS | PSEL1=1, PENABLE=1; waits for PREADY or timeout, may regrant
module apb_master_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      PRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      busy,
  apb_master_arbiter_if.master      apb
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SETUP, S_ACCESS} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   wait_cnt;

  logic               gnt_any;
  logic [PTR_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] own_oh;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_write;
  logic               timeout_hit;

  // Round-robin search: indices above rr_ptr first, then wrap to 0..rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req_valid[i] && (PTR_W'(i) > rr_ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && req_valid[i] && (PTR_W'(i) <= rr_ptr)) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
  end

  // Winner payload mux plus one-hot views of winner and current owner (rr_ptr).
  always_comb begin
    gnt_oh    = '0;
    own_oh    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_oh[i] = (rr_ptr == PTR_W'(i));
      if (gnt_idx == PTR_W'(i)) begin
        gnt_oh[i] = gnt_any;
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_write = req_write[i];
      end
    end
  end

  // The counter holds the number of PREADY=0 ACCESS cycles already seen,
  // so this cycle is the last allowed one when it equals TIMEOUT_CYC-1.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Sequencer: every output is a register written here.
  always_ff @(posedge clk) begin
    if (PRESET) begin
      state       <= S_IDLE;
      rr_ptr      <= PTR_W'(NUM_REQ - 1);
      wait_cnt    <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      apb.PSEL1   <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            req_ready  <= gnt_oh;
            apb.PADDR  <= sel_addr;
            apb.PWDATA <= sel_wdata;
            apb.PWRITE <= sel_write;
            rr_ptr     <= gnt_idx;
            busy       <= 1'b1;
            state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          apb.PSEL1 <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_SETUP;
        end
        S_SETUP: begin
          apb.PENABLE <= 1'b1;
          state       <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb.PREADY || timeout_hit) begin
            rsp_valid   <= own_oh;
            rsp_rdata   <= apb.PREADY ? apb.PRDATA : '0;
            rsp_slverr  <= apb.PREADY ? apb.PSLVERR : 1'b1;
            rsp_timeout <= !apb.PREADY;
            apb.PENABLE <= 1'b0;
            if (gnt_any) begin
              // Back-to-back: this next cycle is already the new SETUP phase.
              req_ready  <= gnt_oh;
              apb.PADDR  <= sel_addr;
              apb.PWDATA <= sel_wdata;
              apb.PWRITE <= sel_write;
              rr_ptr     <= gnt_idx;
              wait_cnt   <= '0;
              state      <= S_SETUP;
            end else begin
              apb.PSEL1 <= 1'b0;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Round-robin arbiter plus APB master sequencer. It shares one APB bus (PSEL1/PENABLE/PADDR/PWDATA/PWRITE) between NUM_REQ local requesters.
- It runs each granted transfer through the SETUP and ACCESS phases, waits for PREADY, and routes PRDATA/PSLVERR back to the owning requester.
- It bounds slave wait states with a timeout counter, so the bus sequence always meets the PSEL1→PENABLE and signal-stability rules.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 32, PADDR / req_addr width per requester.
- DATA_W, 32, PWDATA/PRDATA width.
- TIMEOUT_CYC, 16, max ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- clk  in  1  bus clock; all logic on posedge.
- PRESET  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- req_write  in  NUM_REQ  per-requester direction, 1=write.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid.
- rsp_slverr  out  1  PSLVERR or timeout; valid with rsp_valid.
- rsp_timeout  out  1  transfer aborted by timeout; valid with rsp_valid.
- busy  out  1  state != IDLE.
- PSEL1, PENABLE, PWRITE  out  1  APB controls.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY, PSLVERR  in  1  APB slave response.

Behaviour:
- All outputs are registered.
- Reset (PRESET=1 at posedge) forces state IDLE, rr_ptr=NUM_REQ-1, and timeout count 0. It also drives every output to 0: PSEL1, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout, busy.
- Reset mid-transfer drops PSEL1/PENABLE the next cycle. The aborted transfer gets no rsp_valid.
- Arbitration happens in IDLE, or in ACCESS on the completion cycle:
  - Search starts at (rr_ptr+1) mod NUM_REQ, then wraps; the first set req_valid bit wins.
  - Winner i gets req_ready[i]=1 for exactly one cycle.
  - Its addr/wdata/write are latched into PADDR/PWDATA/PWRITE, and rr_ptr becomes i.
  - A requester holds req_valid and its payload until it sees req_ready.
- FSM:
  - IDLE: if any req_valid, grant and go to SETUP. PSEL1=0, PENABLE=0.
  - SETUP: PSEL1=1, PENABLE=0; lasts exactly one cycle, then ACCESS.
  - ACCESS: PSEL1=1, PENABLE=1. PADDR/PWDATA/PWRITE/PSEL1 are held stable from SETUP through the last ACCESS cycle.
  - ACCESS, PREADY=1 sampled: on the next cycle, rsp_valid[owner]=1 for one cycle, rsp_rdata=PRDATA (captured for both reads and writes), rsp_slverr=PSLVERR, rsp_timeout=0. PENABLE deasserts that same next cycle. If any req_valid is set, grant and go to SETUP (PSEL1 stays 1, back-to-back); otherwise go to IDLE (PSEL1=0).
  - ACCESS, PREADY=0: wait counter increments. If TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC, terminate as for completion but with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0. The counter clears on every SETUP entry.
- Latency: grant to PSEL1 rise is 1 cycle. PENABLE rises 2 cycles after grant. rsp_valid follows the PREADY sample by 1 cycle.
- Minimum transfer length is 3 cycles (grant → SETUP → ACCESS), giving back-to-back throughput of 1 transfer per 2 cycles, plus wait states.
- A requester that deasserts req_valid before grant is simply not granted; no error.
- A requester may re-request in the same cycle its rsp_valid is high.
- PSLVERR is only meaningful when PREADY=1 and is ignored otherwise.

Test Plan:
- Reset: hold PRESET 3 cycles with req_valid=4'b1111 → all outputs 0, no req_ready. After release, req_ready[0] pulses first.
- Single write, zero wait: req 2 writes addr 0x10, data 0xDEADBEEF, PREADY tied 1 → req_ready[2] at T0, PSEL1 at T1, PENABLE at T2, rsp_valid[2] at T3 with rsp_slverr=0, busy=0 at T3.
- Read, 3 wait states: req 1 reads 0x20, PREADY low for 3 ACCESS cycles, then high with PRDATA=0x12345678 → PADDR stable throughout, rsp_rdata=0x12345678 on rsp_valid[1].
- Contention: all 4 requesters hold req_valid, PREADY=1 → grant order 0,1,2,3,0. PSEL1 stays high between back-to-back transfers; PENABLE goes low for exactly one cycle between them.
- Timeout: TIMEOUT_CYC=16, PREADY held 0 → abort after 16 ACCESS cycles with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0, PSEL1/PENABLE low on the following cycle.
- Error and reset mid-op: PREADY=1 with PSLVERR=1 → rsp_slverr=1, rsp_timeout=0. Then assert PRESET during ACCESS → PSEL1/PENABLE go to 0 the next cycle and no rsp_valid.
